// File: rtl/axil_write_queue_if.sv
// rtl/axil_write_queue_if.sv - request stream and write-handler bus of the AXI-lite write queue
interface axil_write_queue_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
);
   localparam int LVL_WIDTH = $clog2(DEPTH) + 1;

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_addr;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  wr_start;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;
   logic [LVL_WIDTH-1:0]  level;
   logic                  idle;

   // Queue side: consumes requests, drives the write handler's user API.
   modport slave (
      input  in_valid, in_addr, in_data, wr_ready,
      output in_ready, wr_start, wr_addr, wr_data, level, idle
   );

   // Datapath/handler side as seen by the environment around the queue.
   modport master (
      output in_valid, in_addr, in_data, wr_ready,
      input  in_ready, wr_start, wr_addr, wr_data, level, idle
   );
endinterface

// File: rtl/axil_write_queue.sv
// rtl/axil_write_queue.sv - register FIFO feeding the AXI-lite write handler; optional AXIL_WRITE_QUEUE_STATS_EN
module axil_write_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 4
) (
   input  logic               clk,
   input  logic               rst,
   axil_write_queue_if.slave  bus
`ifdef AXIL_WRITE_QUEUE_STATS_EN
   ,
   output logic [15:0]        done_count,
   output logic [15:0]        issue_count
`endif
);
   localparam int PTR_WIDTH = $clog2(DEPTH);
   localparam int LVL_WIDTH = PTR_WIDTH + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOLD = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
   logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
   logic [LVL_WIDTH-1:0]  level_q, level_d;
   logic                  wr_start_q, wr_start_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  in_ready;
   logic                  push;
   logic                  issue;

   // No full bypass: a pop in the same cycle never lets a full queue accept.
   assign in_ready = (level_q != LVL_WIDTH'(DEPTH));
   assign push     = bus.in_valid && in_ready;

   assign bus.in_ready = in_ready;
   assign bus.wr_start = wr_start_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.level    = level_q;
   assign bus.idle     = (level_q == '0) && (state_q == S_IDLE);

   // FIFO storage; contents need no reset since pointers define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= bus.in_addr;
         data_mem_q[wr_ptr_q] <= bus.in_data;
      end
   end

   // Pointer and occupancy next-state; pointers wrap by natural overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      end
      if (issue) begin
         rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end
      case ({push, issue})
         2'b10:   level_d = level_q + LVL_WIDTH'(1);
         2'b01:   level_d = level_q - LVL_WIDTH'(1);
         default: level_d = level_q;
      endcase
   end

   // State register plus registered handler outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         wr_start_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         wr_start_q <= wr_start_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Next state: HOLD skips wr_ready because the handler's ready lags start by a clock.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (issue) state_d = S_HOLD;
         S_HOLD:  state_d = S_WAIT;
         S_WAIT:  if (bus.wr_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: issue the FIFO head only from IDLE; address/data hold until the next issue.
   always_comb begin
      issue      = (state_q == S_IDLE) && (level_q != '0) && bus.wr_ready;
      wr_start_d = issue;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      if (issue) begin
         wr_addr_d = addr_mem_q[rd_ptr_q];
         wr_data_d = data_mem_q[rd_ptr_q];
      end
   end

`ifdef AXIL_WRITE_QUEUE_STATS_EN
   logic [15:0] done_count_q;
   logic [15:0] issue_count_q;

   assign done_count  = done_count_q;
   assign issue_count = issue_count_q;

   // Free-running wrap-around counters of issued and completed writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_count_q  <= '0;
         issue_count_q <= '0;
      end else begin
         if (issue) begin
            issue_count_q <= issue_count_q + 16'd1;
         end
         if ((state_q == S_WAIT) && bus.wr_ready) begin
            done_count_q <= done_count_q + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_axil_write_queue.sv
// tb/tb_axil_write_queue.sv - directed bench for axil_write_queue
module tb_axil_write_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_ready = 1'b1;
   logic model_en = 1'b0;
   logic model_ready;
   int   model_cnt;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_start = -1;
   int   spacing_err = 0;
   logic [31:0] log_data[$];
   logic [4:0]  log_addr[$];

   axil_write_queue_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) bus ();

`ifdef AXIL_WRITE_QUEUE_STATS_EN
   logic [15:0] done_count;
   logic [15:0] issue_count;
`endif

   axil_write_queue #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef AXIL_WRITE_QUEUE_STATS_EN
      ,
      .done_count  (done_count),
      .issue_count (issue_count)
`endif
   );

   always #5 clk = ~clk;

   assign bus.wr_ready = model_en ? model_ready : tb_ready;

   always @(posedge clk) cyc++;

   // Handler model: ready drops the clock after start, returns 3 clocks later.
   always @(posedge clk) begin
      if (rst || !model_en) begin
         model_ready <= 1'b1;
         model_cnt   <= 0;
      end else if (bus.wr_start) begin
         model_ready <= 1'b0;
         model_cnt   <= 3;
      end else if (model_cnt != 0) begin
         model_cnt <= model_cnt - 1;
         if (model_cnt == 1) model_ready <= 1'b1;
      end
   end

   // Issue monitor: logs every start and flags starts closer than 3 clocks.
   always @(negedge clk) begin
      if (rst) begin
         last_start = -1;
      end else if (bus.wr_start) begin
         log_data.push_back(bus.wr_data);
         log_addr.push_back(bus.wr_addr);
         if (last_start >= 0 && (cyc - last_start) < 3) spacing_err++;
         last_start = cyc;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_req(input logic [4:0] a, input logic [31:0] d);
      logic accepted;
      accepted = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_addr  = a;
      bus.in_data  = d;
      for (int t = 0; t < 100 && !accepted; t++) begin
         accepted = bus.in_ready;
         step();
      end
      bus.in_valid = 1'b0;
      check("push_accept", accepted, 1);
   endtask

   task automatic wait_idle(input string tag);
      for (int t = 0; t < 300 && !bus.idle; t++) step();
      check(tag, bus.idle, 1);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_addr  = '0;
      bus.in_data  = '0;

      // Reset state
      step(); step(); step();
      check("rst_wr_start", bus.wr_start, 0);
      check("rst_wr_addr", bus.wr_addr, 0);
      check("rst_wr_data", bus.wr_data, 0);
      check("rst_level", bus.level, 0);
      check("rst_idle", bus.idle, 1);
      check("rst_in_ready", bus.in_ready, 1);
      rst = 1'b0;
      step();

      // Single write: start appears in the cycle after edge N+1
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'd1;
      bus.in_data  = 32'd2345;
      step();
      bus.in_valid = 1'b0;
      check("single_level_push", bus.level, 1);
      check("single_no_start_yet", bus.wr_start, 0);
      step();
      check("single_start", bus.wr_start, 1);
      check("single_addr", bus.wr_addr, 1);
      check("single_data", bus.wr_data, 2345);
      check("single_level_pop", bus.level, 0);
      check("single_busy", bus.idle, 0);
      tb_ready = 1'b0;
      step();
      check("single_start_low", bus.wr_start, 0);
      check("single_data_held", bus.wr_data, 2345);
      step();
      check("single_wait_busy", bus.idle, 0);
      tb_ready = 1'b1;
      step();
      check("single_idle", bus.idle, 1);
      check("single_one_start", log_data.size(), 1);

      // Fill with handler busy: 5th request held until a pop
      log_data.delete();
      log_addr.delete();
      tb_ready = 1'b0;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.in_addr = 5'(k);
         bus.in_data = 32'(100 + k);
         step();
         check("fill_level", bus.level, 64'(k + 1));
      end
      bus.in_addr = 5'd4;
      bus.in_data = 32'd104;
      check("full_in_ready", bus.in_ready, 0);
      step(); step();
      check("full_level_held", bus.level, 4);
      check("full_no_start", log_data.size(), 0);
      tb_ready = 1'b1;
      step();
      check("full_pop_level", bus.level, 3);
      check("full_pop_start", bus.wr_start, 1);
      check("full_pop_data", bus.wr_data, 100);
      tb_ready = 1'b0;
      step();
      check("full_fifth_in", bus.level, 4);
      bus.in_valid = 1'b0;
      model_en = 1'b1;
      wait_idle("fill_drain_idle");
      check("fill_count", log_data.size(), 5);
      for (int k = 0; k < 5 && k < log_data.size(); k++) begin
         check("fill_order", log_data[k], 64'(100 + k));
      end

      // Ordering and pointer wrap with the handler model
      log_data.delete();
      log_addr.delete();
      for (int k = 0; k < 10; k++) push_req(5'(k), 32'(k));
      wait_idle("order_idle");
      check("order_count", log_data.size(), 10);
      for (int k = 0; k < 10 && k < log_data.size(); k++) begin
         check("order_data", log_data[k], 64'(k));
         check("order_addr", log_addr[k], 64'(k));
      end
      check("order_spacing", spacing_err, 0);

      // Simultaneous push and pop at level 2
      model_en = 1'b0;
      tb_ready = 1'b0;
      log_data.delete();
      log_addr.delete();
      push_req(5'd3, 32'hA1);
      push_req(5'd4, 32'hB2);
      check("pp_level_before", bus.level, 2);
      bus.in_valid = 1'b1;
      bus.in_addr  = 5'd5;
      bus.in_data  = 32'hC3;
      tb_ready = 1'b1;
      step();
      check("pp_level_same", bus.level, 2);
      check("pp_start", bus.wr_start, 1);
      check("pp_data", bus.wr_data, 32'hA1);
      bus.in_valid = 1'b0;
      tb_ready = 1'b0;
      model_en = 1'b1;
      wait_idle("pp_idle");
      check("pp_count", log_data.size(), 3);
      if (log_data.size() == 3) begin
         check("pp_order0", log_data[0], 32'hA1);
         check("pp_order1", log_data[1], 32'hB2);
         check("pp_order2", log_data[2], 32'hC3);
      end

      // Reset while in WAIT with level 3
      model_en = 1'b0;
      tb_ready = 1'b0;
      log_data.delete();
      log_addr.delete();
      for (int k = 0; k < 4; k++) push_req(5'(k), 32'(8'hD0 + k));
      tb_ready = 1'b1;
      step();
      tb_ready = 1'b0;
      step(); step();
      check("mid_level", bus.level, 3);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_level", bus.level, 0);
      check("mid_rst_start", bus.wr_start, 0);
      check("mid_rst_data", bus.wr_data, 0);
      check("mid_rst_idle", bus.idle, 1);
      check("mid_rst_in_ready", bus.in_ready, 1);
      tb_ready = 1'b1;
      for (int k = 0; k < 10; k++) step();
      check("mid_no_reissue", log_data.size(), 1);
      check("mid_level_after", bus.level, 0);

`ifdef AXIL_WRITE_QUEUE_STATS_EN
      // Statistics counters and their wrap
      check("stats_rst_issue", issue_count, 0);
      check("stats_rst_done", done_count, 0);
      model_en = 1'b1;
      for (int k = 0; k < 7; k++) push_req(5'(k), 32'(k));
      wait_idle("stats_idle");
      check("stats_issue7", issue_count, 7);
      check("stats_done7", done_count, 7);
      force dut.issue_count_q = 16'hFFFF;
      force dut.done_count_q  = 16'hFFFF;
      #1;
      release dut.issue_count_q;
      release dut.done_count_q;
      check("stats_forced", issue_count, 16'hFFFF);
      push_req(5'd9, 32'd9);
      wait_idle("stats_wrap_idle");
      check("stats_issue_wrap", issue_count, 0);
      check("stats_done_wrap", done_count, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
